store_buffer: RTL and testbench

- Posted-write FIFO between the single-cycle core's data port (MemWrite/DataAdr/WriteData) and a slower data memory with a valid/ready write port.
- Core stores retire into the buffer in one cycle. The buffer drains them in order to memory.
- Loads are checked against buffered stores and served by word forwarding on a hit, so the core never reads stale data.

---
 rtl/sb_pkg.sv | 20 ++
 rtl/sb_fwd_match.sv | 34 +++
 rtl/store_buffer.sv | 93 +++++++++
 tb/tb_store_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer.
// Entry widths follow the default address/data widths below.
package sb_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;
  localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned SB_CNT_W = SB_PTR_W + 1;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic logic [SB_AW-3:0] word_idx(input logic [SB_AW-1:0] addr);
    return addr[SB_AW-1:2];
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Load-forwarding lookup: finds the youngest occupied entry whose word matches ld_addr.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           occupied,
  input  logic [$clog2(DEPTH)-1:0]   tail,
  input  logic [SB_AW-1:0]           ld_addr,
  output logic                       ld_hit,
  output logic [SB_DW-1:0]           ld_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] idx;

  // Walk backward from the youngest slot; the first occupied match wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = tail - PtrW'(k + 1);
      if (!ld_hit && occupied[idx] &&
          (word_idx(entries[idx].addr) == word_idx(ld_addr))) begin
        ld_hit  = 1'b1;
        ld_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO drain to memory with load forwarding.
// AW/DW must match the package entry widths.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     mem_valid,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  input  logic                     mem_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  sb_entry_t        entries_q [DEPTH];
  logic [DEPTH-1:0] occupied;
  logic             push, pop;

  assign st_ready  = (count_q != CntW'(DEPTH));
  assign mem_valid = (count_q != '0);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign mem_addr  = entries_q[head_q].addr;
  assign mem_data  = entries_q[head_q].data;
  assign push      = st_valid & st_ready;
  assign pop       = mem_valid & mem_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from head is below the occupancy count.
  always_comb begin
    occupied = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupied[i] = ({1'b0, PtrW'(i) - head_q} < count_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= '{addr: st_addr, data: st_data};
  end

  sb_fwd_match #(
    .DEPTH(DEPTH)
  ) u_fwd (
    .entries (entries_q),
    .occupied(occupied),
    .tail    (tail_q),
    .ld_addr (ld_addr),
    .ld_hit  (ld_hit),
    .ld_data (ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          empty;
  logic [2:0]    count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ready(mem_ready),
    .empty    (empty),
    .count    (count)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t model_q[$];

  typedef struct {
    logic          sv;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic          mr;
    logic [AW-1:0] la;
    logic [2:0]    cnt;
    logic          sr;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          hit;
    logic [DW-1:0] ld;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the buffer is an ordered list; the youngest word match is the last one.
  task automatic check_model(input string tag);
    logic          e_hit;
    logic [DW-1:0] e_data;
    e_hit  = 1'b0;
    e_data = '0;
    foreach (model_q[i]) begin
      if (model_q[i].addr[AW-1:2] == ld_addr[AW-1:2]) begin
        e_hit  = 1'b1;
        e_data = model_q[i].data;
      end
    end
    chk({tag, ".st_ready"},  st_ready,  model_q.size() < DEPTH);
    chk({tag, ".mem_valid"}, mem_valid, model_q.size() != 0);
    chk({tag, ".count"},     count,     model_q.size());
    chk({tag, ".empty"},     empty,     model_q.size() == 0);
    chk({tag, ".ld_hit"},    ld_hit,    e_hit);
    chk({tag, ".ld_data"},   ld_data,   e_data);
    if (model_q.size() != 0) begin
      chk({tag, ".mem_addr"}, mem_addr, model_q[0].addr);
      chk({tag, ".mem_data"}, mem_data, model_q[0].data);
    end
  endtask

  task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic mr, input logic [AW-1:0] la);
    st_valid  = sv;
    st_addr   = sa;
    st_data   = sd;
    mem_ready = mr;
    ld_addr   = la;
    #1;
  endtask

  task automatic tick();
    bit do_push;
    bit do_pop;
    ent_t e;
    do_push = st_valid && (model_q.size() < DEPTH);
    do_pop  = (model_q.size() != 0) && mem_ready;
    e.addr  = st_addr;
    e.data  = st_data;
    @(posedge clk);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(e);
    #1;
  endtask

  task automatic cycle(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic mr, input logic [AW-1:0] la, input string tag);
    drive(sv, sa, sd, mr, la);
    check_model(tag);
    tick();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h60, 32'h5,  1'b1, 32'h0,  3'd0, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,  32'h0,  1'b1, 32'h60, 3'd1, 1'b1, 1'b1, 32'h60, 32'h5,  1'b1, 32'h5};
    vecs[2]  = '{1'b1, 32'h64, 32'h3,  1'b0, 32'h66, 3'd0, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h64, 32'h7,  1'b0, 32'h66, 3'd1, 1'b1, 1'b1, 32'h64, 32'h3,  1'b1, 32'h3};
    vecs[4]  = '{1'b1, 32'h00, 32'h11, 1'b0, 32'h66, 3'd2, 1'b1, 1'b1, 32'h64, 32'h3,  1'b1, 32'h7};
    vecs[5]  = '{1'b1, 32'h0C, 32'h22, 1'b0, 32'h68, 3'd3, 1'b1, 1'b1, 32'h64, 32'h3,  1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h10, 32'h33, 1'b0, 32'h0E, 3'd4, 1'b0, 1'b1, 32'h64, 32'h3,  1'b1, 32'h22};
    vecs[7]  = '{1'b1, 32'h10, 32'h33, 1'b1, 32'h64, 3'd4, 1'b0, 1'b1, 32'h64, 32'h3,  1'b1, 32'h7};
    vecs[8]  = '{1'b1, 32'h10, 32'h33, 1'b1, 32'h64, 3'd3, 1'b1, 1'b1, 32'h64, 32'h7,  1'b1, 32'h7};
    vecs[9]  = '{1'b0, 32'h0,  32'h0,  1'b1, 32'h10, 3'd3, 1'b1, 1'b1, 32'h00, 32'h11, 1'b1, 32'h33};
    vecs[10] = '{1'b0, 32'h0,  32'h0,  1'b1, 32'h00, 3'd2, 1'b1, 1'b1, 32'h0C, 32'h22, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0,  32'h0,  1'b1, 32'h10, 3'd1, 1'b1, 1'b1, 32'h10, 32'h33, 1'b1, 32'h33};
    vecs[12] = '{1'b0, 32'h0,  32'h0,  1'b0, 32'h10, 3'd0, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0};

    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b1;
    #1;

    // Directed table: outputs are checked before the edge that consumes the row's inputs.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].mr, vecs[i].la);
      chk($sformatf("vec%0d.count", i),     count,     vecs[i].cnt);
      chk($sformatf("vec%0d.empty", i),     empty,     vecs[i].cnt == 0);
      chk($sformatf("vec%0d.st_ready", i),  st_ready,  vecs[i].sr);
      chk($sformatf("vec%0d.mem_valid", i), mem_valid, vecs[i].mv);
      chk($sformatf("vec%0d.ld_hit", i),    ld_hit,    vecs[i].hit);
      chk($sformatf("vec%0d.ld_data", i),   ld_data,   vecs[i].ld);
      if (vecs[i].mv) begin
        chk($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].ma);
        chk($sformatf("vec%0d.mem_data", i), mem_data, vecs[i].md);
      end
      tick();
    end

    // Youngest-match across the wrap: older 0x20 store in the last slot, newer in slot 0.
    cycle(1'b1, 32'h04, 32'h1, 1'b0, 32'h20, "wrap0");
    cycle(1'b1, 32'h20, 32'hB, 1'b0, 32'h20, "wrap1");
    cycle(1'b1, 32'h20, 32'hA, 1'b0, 32'h20, "wrap2");
    drive(1'b0, '0, '0, 1'b0, 32'h20);
    chk("wrap.ld_hit", ld_hit, 1'b1);
    chk("wrap.ld_data", ld_data, 32'hA);
    tick();
    cycle(1'b0, '0, '0, 1'b1, 32'h20, "wrap3");
    drive(1'b0, '0, '0, 1'b0, 32'h22);
    chk("wrap_pop.ld_data", ld_data, 32'hA);
    tick();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 32'h20, "wrap_drain");

    // Asynchronous reset mid-drain must drop everything without a clock edge.
    cycle(1'b1, 32'h40, 32'h1, 1'b0, 32'h0, "rst_fill");
    cycle(1'b1, 32'h44, 32'h2, 1'b0, 32'h0, "rst_fill");
    cycle(1'b1, 32'h48, 32'h3, 1'b0, 32'h0, "rst_fill");
    drive(1'b0, '0, '0, 1'b1, 32'h44);
    check_model("pre_rst");
    reset = 1'b0;
    #1;
    chk("rst_async.mem_valid", mem_valid, 1'b0);
    chk("rst_async.empty", empty, 1'b1);
    chk("rst_async.st_ready", st_ready, 1'b1);
    chk("rst_async.count", count, 3'd0);
    chk("rst_async.ld_hit", ld_hit, 1'b0);
    model_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 32'h44, "post_rst");

    // Random traffic over a small address window so word hits and full stalls are common.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] sa;
      logic [AW-1:0] la;
      sa = AW'({$urandom_range(0, 7), 2'b00}) | AW'($urandom_range(0, 3));
      la = AW'({$urandom_range(0, 7), 2'b00}) | AW'($urandom_range(0, 3));
      cycle($urandom_range(0, 2) != 0, sa, DW'($urandom), $urandom_range(0, 2) == 0, la,
            "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
